// File: rtl/axi_sram_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_sram_pkg : shared types, response/burst codes, index helper  |
// | Revision     : 1.0                                               |
// +------------------------------------------------------------------+
package axi_sram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_DATA = 2'd1,
    R_WAIT = 2'd2
  } r_state_e;

  // Byte offset from the window base to a word index.
  function automatic logic [63:0] idx_calc(input logic [63:0] byte_off,
                                           input int unsigned shift);
    return byte_off >> shift;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_array.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_sram_array : 1R1W word SRAM, byte-enable write, registered rd |
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module axi_sram_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned IDX_W      = $clog2(MEM_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    we_i,
  input  logic [IDX_W-1:0]        waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    re_i,
  input  logic [IDX_W-1:0]        raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is intentionally left without reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // A same-cycle write to raddr_i is not visible here: read-before-write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/axi_sram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_sram_slave : AXI4 INCR/single-beat slave over a 1R1W SRAM    |
// | Option AXI_SRAM_RD_LAT_EN adds RD_LATENCY cycles to first R beat.|
// | Revision       : 1.0                                             |
// +------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter int unsigned          DATA_WIDTH = 32,
  parameter int unsigned          ID_WIDTH   = 4,
  parameter int unsigned          MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned          RD_LATENCY = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [ID_WIDTH-1:0]     axi_aw_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_aw_addr_i,
  input  logic [7:0]              axi_aw_len_i,
  input  logic [1:0]              axi_aw_burst_i,
  input  logic                    axi_aw_valid_i,
  output logic                    axi_aw_ready_o,
  input  logic [DATA_WIDTH-1:0]   axi_w_data_i,
  input  logic [DATA_WIDTH/8-1:0] axi_w_strb_i,
  input  logic                    axi_w_last_i,
  input  logic                    axi_w_valid_i,
  output logic                    axi_w_ready_o,
  output logic [ID_WIDTH-1:0]     axi_b_id_o,
  output logic [1:0]              axi_b_resp_o,
  output logic                    axi_b_valid_o,
  input  logic                    axi_b_ready_i,
  input  logic [ID_WIDTH-1:0]     axi_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   axi_ar_addr_i,
  input  logic [7:0]              axi_ar_len_i,
  input  logic [1:0]              axi_ar_burst_i,
  input  logic                    axi_ar_valid_i,
  output logic                    axi_ar_ready_o,
  output logic [ID_WIDTH-1:0]     axi_r_id_o,
  output logic [DATA_WIDTH-1:0]   axi_r_data_o,
  output logic [1:0]              axi_r_resp_o,
  output logic                    axi_r_last_o,
  output logic                    axi_r_valid_o,
  input  logic                    axi_r_ready_i
);

  import axi_sram_pkg::*;

  localparam int unsigned STRB  = DATA_WIDTH / 8;
  localparam int unsigned SHIFT = $clog2(STRB);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  // Readies stay low in reset and rise on the first edge after release.
  logic rdy_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdy_q <= 1'b0;
    else         rdy_q <= 1'b1;
  end

  logic [ADDR_WIDTH:0] aw_off, ar_off;
  logic [63:0]         aw_idx, ar_idx;
  logic                aw_err, ar_err;

  always_comb begin
    aw_off = {1'b0, axi_aw_addr_i} - {1'b0, BASE_ADDR};
    ar_off = {1'b0, axi_ar_addr_i} - {1'b0, BASE_ADDR};
    aw_idx = idx_calc(64'(aw_off[ADDR_WIDTH-1:0]), SHIFT);
    ar_idx = idx_calc(64'(ar_off[ADDR_WIDTH-1:0]), SHIFT);
    aw_err = aw_off[ADDR_WIDTH] || (axi_aw_burst_i != BURST_INCR) ||
             (aw_idx + 64'(axi_aw_len_i) >= 64'(MEM_WORDS));
    ar_err = ar_off[ADDR_WIDTH] || (axi_ar_burst_i != BURST_INCR) ||
             (ar_idx + 64'(axi_ar_len_i) >= 64'(MEM_WORDS));
  end

  // ---------------- write channel ----------------
  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [7:0]          w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                w_aerr_q, w_aerr_d, w_lerr_q, w_lerr_d;
  logic                w_last_beat, mem_we;
  logic                aw_ready, w_ready, b_valid;

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_idx_d     = w_idx_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_aerr_d    = w_aerr_q;
    w_lerr_d    = w_lerr_q;
    aw_ready    = 1'b0;
    w_ready     = 1'b0;
    b_valid     = 1'b0;
    mem_we      = 1'b0;
    w_last_beat = (w_cnt_q == w_len_q);
    case (w_state_q)
      W_IDLE: begin
        aw_ready = rdy_q;
        if (axi_aw_valid_i && rdy_q) begin
          w_id_d    = axi_aw_id_i;
          w_idx_d   = aw_idx[IDX_W-1:0];
          w_len_d   = axi_aw_len_i;
          w_cnt_d   = 8'd0;
          w_aerr_d  = aw_err;
          w_lerr_d  = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi_w_valid_i) begin
          mem_we  = !w_aerr_q;
          w_idx_d = w_idx_q + IDX_W'(1);
          w_cnt_d = w_cnt_q + 8'd1;
          // A misplaced WLAST only taints the response; the count ends the burst.
          if (axi_w_last_i != w_last_beat) w_lerr_d = 1'b1;
          if (w_last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_b_ready_i) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_aerr_q  <= 1'b0;
      w_lerr_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_aerr_q  <= w_aerr_d;
      w_lerr_q  <= w_lerr_d;
    end
  end

  assign axi_aw_ready_o = aw_ready;
  assign axi_w_ready_o  = w_ready;
  assign axi_b_valid_o  = b_valid;
  assign axi_b_id_o     = w_id_q;
  assign axi_b_resp_o   = (b_valid && (w_aerr_q || w_lerr_q)) ? RESP_SLVERR : RESP_OKAY;

  // ---------------- read channel ----------------
  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d, rd_addr;
  logic [7:0]          r_len_q, r_len_d, r_cnt_q, r_cnt_d;
  logic                r_err_q, r_err_d;
  logic                rd_en, ar_ready, r_valid, r_last_beat;
  logic [DATA_WIDTH-1:0] arr_rdata;
`ifdef AXI_SRAM_RD_LAT_EN
  logic [7:0]          r_lat_q, r_lat_d;
`endif

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_idx_d     = r_idx_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_err_d     = r_err_q;
    rd_en       = 1'b0;
    rd_addr     = r_idx_q;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    r_last_beat = (r_cnt_q == r_len_q);
`ifdef AXI_SRAM_RD_LAT_EN
    r_lat_d     = r_lat_q;
`endif
    case (r_state_q)
      R_IDLE: begin
        ar_ready = rdy_q;
        if (axi_ar_valid_i && rdy_q) begin
          r_id_d    = axi_ar_id_i;
          r_len_d   = axi_ar_len_i;
          r_cnt_d   = 8'd0;
          r_err_d   = ar_err;
          rd_en     = 1'b1;
          rd_addr   = ar_idx[IDX_W-1:0];
          // r_idx always points at the next word to prefetch.
          r_idx_d   = ar_idx[IDX_W-1:0] + IDX_W'(1);
          r_state_d = R_DATA;
`ifdef AXI_SRAM_RD_LAT_EN
          r_lat_d   = 8'd0;
          if (RD_LATENCY != 0) r_state_d = R_WAIT;
`endif
        end
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (axi_r_ready_i) begin
          if (r_last_beat) begin
            r_state_d = R_IDLE;
          end else begin
            rd_en   = 1'b1;
            r_idx_d = r_idx_q + IDX_W'(1);
            r_cnt_d = r_cnt_q + 8'd1;
          end
        end
      end
`ifdef AXI_SRAM_RD_LAT_EN
      R_WAIT: begin
        if (r_lat_q == 8'(RD_LATENCY - 1)) r_state_d = R_DATA;
        else                               r_lat_d   = r_lat_q + 8'd1;
      end
`endif
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
`ifdef AXI_SRAM_RD_LAT_EN
      r_lat_q   <= '0;
`endif
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
`ifdef AXI_SRAM_RD_LAT_EN
      r_lat_q   <= r_lat_d;
`endif
    end
  end

  axi_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .we_i    (mem_we),
    .waddr_i (w_idx_q),
    .wdata_i (axi_w_data_i),
    .wstrb_i (axi_w_strb_i),
    .re_i    (rd_en),
    .raddr_i (rd_addr),
    .rdata_o (arr_rdata)
  );

  assign axi_ar_ready_o = ar_ready;
  assign axi_r_valid_o  = r_valid;
  assign axi_r_id_o     = r_id_q;
  assign axi_r_data_o   = r_err_q ? '0 : arr_rdata;
  assign axi_r_last_o   = r_valid && r_last_beat;
  assign axi_r_resp_o   = (r_valid && r_err_q) ? RESP_SLVERR : RESP_OKAY;

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_axi_sram_slave : directed scoreboard bench for axi_sram_slave |
// | Revision          : 1.0                                          |
// +------------------------------------------------------------------+
module tb_axi_sram_slave;

`ifdef AXI_SRAM_RD_LAT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [1:0]  aw_burst = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [31:0] w_data = '0;
  logic [3:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [3:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [3:0]  ar_id = '0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [1:0]  ar_burst = '0;
  logic        ar_valid = 1'b0;
  logic        ar_ready;
  logic [3:0]  r_id;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic        r_valid;
  logic        r_ready = 1'b0;

  always #5 clk = ~clk;

  axi_sram_slave dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .axi_aw_id_i(aw_id), .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len),
    .axi_aw_burst_i(aw_burst), .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready),
    .axi_w_data_i(w_data), .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
    .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready),
    .axi_b_id_o(b_id), .axi_b_resp_o(b_resp), .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready),
    .axi_ar_id_i(ar_id), .axi_ar_addr_i(ar_addr), .axi_ar_len_i(ar_len),
    .axi_ar_burst_i(ar_burst), .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready),
    .axi_r_id_o(r_id), .axi_r_data_o(r_data), .axi_r_resp_o(r_resp),
    .axi_r_last_o(r_last), .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready)
  );

  typedef struct { logic [1:0] resp; logic [3:0] id; } b_exp_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id; } r_exp_t;

  b_exp_t      bq[$];
  r_exp_t      rq[$];
  logic [31:0] mem_m [0:1023];
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_burst = burst; aw_valid = 1'b1;
    while (aw_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("aw_ready", aw_ready, 1);
    @(negedge clk);
    aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    while (w_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("w_ready", w_ready, 1);
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  task automatic b_recv();
    int n = 0;
    b_exp_t e;
    b_ready = 1'b1;
    while (b_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("b_valid", b_valid, 1);
    e = bq.pop_front();
    chk("b_resp", b_resp, e.resp);
    chk("b_id", b_id, e.id);
    @(negedge clk);
    b_ready = 1'b0;
  endtask

  task automatic write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic [31:0] d0, input logic [3:0] strb,
                       input int last_beat);
    int  idx = int'(addr >> 2);
    bit  aerr = (burst != 2'b01) || (idx + int'(len) >= 1024);
    bit  bad  = aerr || (last_beat != int'(len));
    bq.push_back('{bad ? 2'b10 : 2'b00, id});
    if (!bad) begin
      for (int b = 0; b <= int'(len); b++)
        for (int k = 0; k < 4; k++)
          if (strb[k]) mem_m[idx+b][k*8 +: 8] = (d0 + 32'(b)) >> (k*8);
    end
    aw_send(id, addr, len, burst);
    for (int b = 0; b <= int'(len); b++) w_send(d0 + 32'(b), strb, b == last_beat);
    b_recv();
  endtask

  task automatic rd_push(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int idx = int'(addr >> 2);
    bit err = (idx + int'(len) >= 1024);
    for (int b = 0; b <= int'(len); b++)
      rq.push_back('{err ? 32'h0 : mem_m[idx+b], err ? 2'b10 : 2'b00, b == int'(len), id});
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    ar_id = id; ar_addr = addr; ar_len = len; ar_burst = 2'b01; ar_valid = 1'b1;
    while (ar_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("ar_ready", ar_ready, 1);
    @(negedge clk);
    ar_valid = 1'b0;
  endtask

  // Entered at the first negedge after the AR handshake edge.
  task automatic r_collect(input logic [7:0] len, input bit toggle);
    r_exp_t e;
    repeat (LAT) begin chk("r_valid_lat", r_valid, 0); @(negedge clk); end
    r_ready = !toggle;
    for (int b = 0; b <= int'(len); b++) begin
      chk("r_valid", r_valid, 1);
      e = rq.pop_front();
      chk("r_data", r_data, e.data);
      chk("r_resp", r_resp, e.resp);
      chk("r_last", r_last, e.last);
      chk("r_id", r_id, e.id);
      if (toggle) begin
        r_ready = 1'b0;
        @(negedge clk);
        chk("r_hold_valid", r_valid, 1);
        chk("r_hold_data", r_data, e.data);
      end
      r_ready = 1'b1;
      @(negedge clk);
    end
    r_ready = 1'b0;
    chk("r_valid_end", r_valid, 0);
  endtask

  task automatic read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                      input bit toggle);
    rd_push(id, addr, len);
    ar_send(id, addr, len);
    r_collect(len, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_aw_ready", aw_ready, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_ar_ready", ar_ready, 0);
    chk("rst_b_valid", b_valid, 0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_b_resp", b_resp, 0);
    chk("rst_r_resp", r_resp, 0);
    chk("rst_r_data", r_data, 0);
    chk("rst_ids", {b_id, r_id}, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("rel_aw_ready", aw_ready, 1);
    chk("rel_ar_ready", ar_ready, 1);

    // Single beat write then read
    write(4'h3, 32'h10, 8'd0, 2'b01, 32'hDEADBEEF, 4'hF, 0);
    read(4'h5, 32'h10, 8'd0, 1'b0);

    // Byte strobes
    write(4'h1, 32'h20, 8'd0, 2'b01, 32'h11223344, 4'hF, 0);
    write(4'h2, 32'h20, 8'd0, 2'b01, 32'hAABBCCDD, 4'b0101, 0);
    read(4'h6, 32'h20, 8'd0, 1'b0);

    // INCR burst, streaming then stalled readback
    write(4'h7, 32'h100, 8'd3, 2'b01, 32'd1, 4'hF, 3);
    read(4'h8, 32'h100, 8'd3, 1'b0);
    read(4'h9, 32'h100, 8'd3, 1'b1);

    // Errors: FIXED burst, out-of-range read, early WLAST
    write(4'hA, 32'h10, 8'd0, 2'b00, 32'h12345678, 4'hF, 0);
    read(4'hB, 32'h10, 8'd0, 1'b0);
    read(4'hC, 32'hFF8, 8'd2, 1'b0);
    write(4'hD, 32'h200, 8'd1, 2'b01, 32'h77, 4'hF, 0);

    // Last legal words of the array
    write(4'hE, 32'hFF8, 8'd1, 2'b01, 32'hA0, 4'hF, 1);
    read(4'hF, 32'hFF8, 8'd1, 1'b0);

    // Same-cycle write and read of word 5
    write(4'h1, 32'h14, 8'd0, 2'b01, 32'h55555555, 4'hF, 0);
    bq.push_back('{2'b00, 4'h2});
    aw_send(4'h2, 32'h14, 8'd0, 2'b01);
    rd_push(4'h3, 32'h14, 8'd0);
    mem_m[5] = 32'h66666666;
    w_data = 32'h66666666; w_strb = 4'hF; w_last = 1'b1; w_valid = 1'b1;
    ar_id = 4'h3; ar_addr = 32'h14; ar_len = 8'd0; ar_burst = 2'b01; ar_valid = 1'b1;
    chk("cc_w_ready", w_ready, 1);
    chk("cc_ar_ready", ar_ready, 1);
    @(negedge clk);
    w_valid = 1'b0; ar_valid = 1'b0;
    r_collect(8'd0, 1'b0);
    b_recv();
    read(4'h4, 32'h14, 8'd0, 1'b0);

    // Reset in the middle of a write burst and a read burst
    write(4'h5, 32'h300, 8'd3, 2'b01, 32'h30, 4'hF, 3);
    aw_send(4'h6, 32'h300, 8'd3, 2'b01);
    w_send(32'hF0, 4'hF, 1'b0);
    mem_m[192] = 32'hF0;
    ar_send(4'h7, 32'h300, 8'd3);
    repeat (LAT) @(negedge clk);
    chk("mid_r_valid", r_valid, 1);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_r_valid", r_valid, 0);
    chk("abort_b_valid", b_valid, 0);
    chk("abort_w_ready", w_ready, 0);
    chk("abort_aw_ready", aw_ready, 0);
    chk("abort_ar_ready", ar_ready, 0);
    chk("abort_r_data", r_data, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    b_ready = 1'b1; r_ready = 1'b1;
    @(negedge clk);
    chk("post_aw_ready", aw_ready, 1);
    chk("post_ar_ready", ar_ready, 1);
    for (int i = 0; i < 5; i++) begin
      chk("post_b_valid", b_valid, 0);
      chk("post_r_valid", r_valid, 0);
      @(negedge clk);
    end
    b_ready = 1'b0; r_ready = 1'b0;
    read(4'h8, 32'h300, 8'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
